// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 raster constants, sync polarities and frame-state encoding
// for the DVI timing path.
package video_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic H_POL = 1'b0;
  localparam logic V_POL = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } frame_state_t;

endpackage

// File: rtl/video_axis_counter.sv
// Single raster axis: wrapping position counter plus look-ahead active/sync
// flags evaluated on the value the counter takes at the next edge.
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL,
  parameter int ACTIVE     = H_ACTIVE,
  parameter int SYNC_START = H_ACTIVE + H_FP,
  parameter int SYNC_END   = H_ACTIVE + H_FP + H_SYNC,
  parameter int CW         = 10
) (
  input  logic          pixclk,
  input  logic          reset,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          wrap,
  output logic          active_nxt,
  output logic          sync_nxt
);

  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYN_LO  = CW'(SYNC_START);
  localparam logic [CW-1:0] SYN_HI  = CW'(SYNC_END);

  assign wrap = (count == LAST);

  // Wrap by compare so the counter can never leave 0..TOTAL-1.
  always_comb begin
    count_nxt = count;
    if (advance) begin
      count_nxt = wrap ? '0 : count + CW'(1);
    end
  end

  assign active_nxt = (count_nxt < ACT_END);
  assign sync_nxt   = (count_nxt >= SYN_LO) && (count_nxt < SYN_HI);

  always_ff @(posedge pixclk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/dvi_timing_ctrl.sv
// DVI raster timing: fetch-side position/request LEAD cycles ahead of the
// vde/sync/position stream delivered to the TMDS serializer.
module dvi_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = video_timing_pkg::H_ACTIVE,
  parameter int   H_FP     = video_timing_pkg::H_FP,
  parameter int   H_SYNC   = video_timing_pkg::H_SYNC,
  parameter int   H_BP     = video_timing_pkg::H_BP,
  parameter int   V_ACTIVE = video_timing_pkg::V_ACTIVE,
  parameter int   V_FP     = video_timing_pkg::V_FP,
  parameter int   V_SYNC   = video_timing_pkg::V_SYNC,
  parameter int   V_BP     = video_timing_pkg::V_BP,
  parameter logic H_POL    = video_timing_pkg::H_POL,
  parameter logic V_POL    = video_timing_pkg::V_POL,
  parameter int   LEAD     = 2,
  parameter int   CW       = 10
) (
  input  logic          pixclk,
  input  logic          reset,
  input  logic          run,
  output logic          fetch_req,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          vde,
  output logic          hSync,
  output logic          vSync,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic          line_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic          active;
    logic          hsync;
    logic          vsync;
    logic          fstart;
    logic          lstart;
    logic [CW-1:0] px;
    logic [CW-1:0] py;
  } pix_t;

  localparam pix_t PIX_IDLE = '{active: 1'b0, hsync: ~H_POL, vsync: ~V_POL,
                                fstart: 1'b0, lstart: 1'b0, px: '0, py: '0};

  frame_state_t  state, state_nxt;
  logic [CW-1:0] hc, vc, hc_nxt, vc_nxt;
  logic          h_wrap, v_wrap, h_act_nxt, v_act_nxt, h_sync_nxt, v_sync_nxt;
  logic          advance, frame_end;
  logic          req_nxt, hs_nxt, vs_nxt, fs_nxt, ls_nxt;
  logic          fetch_hs, fetch_vs, fetch_fs, fetch_ls;
  pix_t          fetch_pix;
  pix_t          pipe [LEAD];

  assign advance   = (state != IDLE);
  assign frame_end = h_wrap && v_wrap;

  video_axis_counter #(
    .TOTAL(H_TOT), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP),
    .SYNC_END(H_ACTIVE + H_FP + H_SYNC), .CW(CW)
  ) u_hcount (
    .pixclk(pixclk), .reset(reset), .advance(advance),
    .count(hc), .count_nxt(hc_nxt), .wrap(h_wrap),
    .active_nxt(h_act_nxt), .sync_nxt(h_sync_nxt)
  );

  video_axis_counter #(
    .TOTAL(V_TOT), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP),
    .SYNC_END(V_ACTIVE + V_FP + V_SYNC), .CW(CW)
  ) u_vcount (
    .pixclk(pixclk), .reset(reset), .advance(advance && h_wrap),
    .count(vc), .count_nxt(vc_nxt), .wrap(v_wrap),
    .active_nxt(v_act_nxt), .sync_nxt(v_sync_nxt)
  );

  always_ff @(posedge pixclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frames always complete: run only decides whether the next frame starts.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = RUN;
      RUN:     if (!run) state_nxt = frame_end ? IDLE : DRAIN;
      DRAIN:   if (run) state_nxt = RUN;
               else if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_nxt = 1'b0;
    hs_nxt  = ~H_POL;
    vs_nxt  = ~V_POL;
    fs_nxt  = 1'b0;
    ls_nxt  = 1'b0;
    if (state_nxt != IDLE) begin
      req_nxt = h_act_nxt && v_act_nxt;
      hs_nxt  = h_sync_nxt ? H_POL : ~H_POL;
      vs_nxt  = v_sync_nxt ? V_POL : ~V_POL;
      ls_nxt  = req_nxt && (hc_nxt == '0);
      fs_nxt  = ls_nxt && (vc_nxt == '0);
    end
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      fetch_req <= 1'b0;
      fetch_hs  <= ~H_POL;
      fetch_vs  <= ~V_POL;
      fetch_fs  <= 1'b0;
      fetch_ls  <= 1'b0;
    end else begin
      fetch_req <= req_nxt;
      fetch_hs  <= hs_nxt;
      fetch_vs  <= vs_nxt;
      fetch_fs  <= fs_nxt;
      fetch_ls  <= ls_nxt;
    end
  end

  assign fetch_x   = hc;
  assign fetch_y   = vc;
  assign fetch_pix = '{active: fetch_req, hsync: fetch_hs, vsync: fetch_vs,
                       fstart: fetch_fs, lstart: fetch_ls, px: hc, py: vc};

  // Delay line so RGB requested now lines up with vde LEAD cycles later.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      for (int i = 0; i < LEAD; i++) pipe[i] <= PIX_IDLE;
    end else begin
      pipe[0] <= fetch_pix;
      for (int i = 1; i < LEAD; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign vde         = pipe[LEAD-1].active;
  assign hSync       = pipe[LEAD-1].hsync;
  assign vSync       = pipe[LEAD-1].vsync;
  assign frame_start = pipe[LEAD-1].fstart;
  assign line_start  = pipe[LEAD-1].lstart;
  assign x           = pipe[LEAD-1].px;
  assign y           = pipe[LEAD-1].py;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Scoreboard bench: a raster model pushes expected output per edge, each DUT
// pops its copy LEAD edges later; small-raster DUTs at LEAD 1/2/8 plus full VGA.
module tb_dvi_timing_ctrl;
  import video_timing_pkg::*;

  localparam int S_HA = 16, S_HFP = 4, S_HS = 6, S_HBP = 6;
  localparam int S_VA = 12, S_VFP = 2, S_VS = 2, S_VBP = 4;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
  localparam int CW = 10;

  logic pixclk = 1'b0;
  logic reset, run;
  int   total = 0, bad = 0;

  logic          a_req, a_vde, a_hs, a_vs, a_fs, a_ls;
  logic [CW-1:0] a_fx, a_fy, a_x, a_y;
  logic          b_req, b_vde, b_hs, b_vs, b_fs, b_ls;
  logic [CW-1:0] b_fx, b_fy, b_x, b_y;
  logic          c_req, c_vde, c_hs, c_vs, c_fs, c_ls;
  logic [CW-1:0] c_fx, c_fy, c_x, c_y;
  logic          d_req, d_vde, d_hs, d_vs, d_fs, d_ls;
  logic [CW-1:0] d_fx, d_fy, d_x, d_y;

  always #5 pixclk = ~pixclk;

  dvi_timing_ctrl #(.H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
                    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
                    .LEAD(2), .CW(CW)) dut_a (
    .pixclk(pixclk), .reset(reset), .run(run), .fetch_req(a_req), .fetch_x(a_fx),
    .fetch_y(a_fy), .vde(a_vde), .hSync(a_hs), .vSync(a_vs), .x(a_x), .y(a_y),
    .frame_start(a_fs), .line_start(a_ls));

  dvi_timing_ctrl #(.H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
                    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
                    .LEAD(1), .CW(CW)) dut_b (
    .pixclk(pixclk), .reset(reset), .run(run), .fetch_req(b_req), .fetch_x(b_fx),
    .fetch_y(b_fy), .vde(b_vde), .hSync(b_hs), .vSync(b_vs), .x(b_x), .y(b_y),
    .frame_start(b_fs), .line_start(b_ls));

  dvi_timing_ctrl #(.H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
                    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
                    .LEAD(8), .CW(CW)) dut_c (
    .pixclk(pixclk), .reset(reset), .run(run), .fetch_req(c_req), .fetch_x(c_fx),
    .fetch_y(c_fy), .vde(c_vde), .hSync(c_hs), .vSync(c_vs), .x(c_x), .y(c_y),
    .frame_start(c_fs), .line_start(c_ls));

  dvi_timing_ctrl #(.LEAD(2), .CW(CW)) dut_d (
    .pixclk(pixclk), .reset(reset), .run(run), .fetch_req(d_req), .fetch_x(d_fx),
    .fetch_y(d_fy), .vde(d_vde), .hSync(d_hs), .vSync(d_vs), .x(d_x), .y(d_y),
    .frame_start(d_fs), .line_start(d_ls));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference raster: where the fetch side must be after an edge sampling rst/rn.
  task automatic modelStep(input int ht, input int vt, input bit rst, input bit rn,
                           inout int h, inout int v, inout bit cnt);
    if (rst) begin
      h = 0; v = 0; cnt = 1'b0;
    end else if (!cnt) begin
      if (rn) cnt = 1'b1;
    end else if (h == ht - 1 && v == vt - 1) begin
      h = 0; v = 0;
      if (!rn) cnt = 1'b0;
    end else if (h == ht - 1) begin
      h = 0; v++;
    end else begin
      h++;
    end
  endtask

  function automatic logic [31:0] fetchPack(input int h, input int v, input bit cnt,
                                            input int ha, input int va);
    logic act;
    act = cnt && h < ha && v < va;
    return {11'd0, act, 10'(h), 10'(v)};
  endfunction

  function automatic logic [31:0] outPack(input int h, input int v, input bit cnt,
                                          input int ha, input int va, input int hs0,
                                          input int hs1, input int vs0, input int vs1);
    logic act, hs, vs, fs, ls;
    act = cnt && h < ha && v < va;
    hs  = (cnt && h >= hs0 && h < hs1) ? H_POL : ~H_POL;
    vs  = (cnt && v >= vs0 && v < vs1) ? V_POL : ~V_POL;
    ls  = act && h == 0;
    fs  = ls && v == 0;
    return {7'd0, act, hs, vs, fs, ls, 10'(h), 10'(v)};
  endfunction

  int sh = 0, sv = 0, bh = 0, bv = 0;
  bit scnt = 1'b0, bcnt = 1'b0;
  bit r_s, rn_s;
  int fs_cnt = 0, ls_cnt = 0;
  logic [31:0] sf, so, bf, bo, idle_pk;
  logic [31:0] qa[$], qb[$], qc[$], qd[$];

  always @(posedge pixclk) begin
    r_s  = reset;
    rn_s = run;
    modelStep(S_HT, S_VT, r_s, rn_s, sh, sv, scnt);
    modelStep(H_TOTAL, V_TOTAL, r_s, rn_s, bh, bv, bcnt);
    idle_pk = outPack(0, 0, 1'b0, 1, 1, 1, 1, 1, 1);
    sf = fetchPack(sh, sv, scnt, S_HA, S_VA);
    so = outPack(sh, sv, scnt, S_HA, S_VA, S_HA + S_HFP, S_HA + S_HFP + S_HS,
                 S_VA + S_VFP, S_VA + S_VFP + S_VS);
    bf = fetchPack(bh, bv, bcnt, H_ACTIVE, V_ACTIVE);
    bo = outPack(bh, bv, bcnt, H_ACTIVE, V_ACTIVE, H_ACTIVE + H_FP,
                 H_ACTIVE + H_FP + H_SYNC, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
    if (r_s) begin
      qa.delete(); qb.delete(); qc.delete(); qd.delete();
      for (int i = 0; i < 2; i++) qa.push_back(idle_pk);
      for (int i = 0; i < 1; i++) qb.push_back(idle_pk);
      for (int i = 0; i < 8; i++) qc.push_back(idle_pk);
      for (int i = 0; i < 2; i++) qd.push_back(idle_pk);
    end
    qa.push_back(so); qb.push_back(so); qc.push_back(so); qd.push_back(bo);
    #1;
    checkOutput("a_fetch", {11'd0, a_req, a_fx, a_fy}, sf);
    checkOutput("b_fetch", {11'd0, b_req, b_fx, b_fy}, sf);
    checkOutput("c_fetch", {11'd0, c_req, c_fx, c_fy}, sf);
    checkOutput("d_fetch", {11'd0, d_req, d_fx, d_fy}, bf);
    checkOutput("a_out", {7'd0, a_vde, a_hs, a_vs, a_fs, a_ls, a_x, a_y}, qa.pop_front());
    checkOutput("b_out", {7'd0, b_vde, b_hs, b_vs, b_fs, b_ls, b_x, b_y}, qb.pop_front());
    checkOutput("c_out", {7'd0, c_vde, c_hs, c_vs, c_fs, c_ls, c_x, c_y}, qc.pop_front());
    checkOutput("d_out", {7'd0, d_vde, d_hs, d_vs, d_fs, d_ls, d_x, d_y}, qd.pop_front());
    if (a_fs) fs_cnt++;
    if (a_ls) ls_cnt++;
  end

  task automatic applyStimulus(input bit rst, input bit rn, input int cycles);
    @(negedge pixclk);
    reset = rst;
    run   = rn;
    repeat (cycles - 1) @(negedge pixclk);
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    run   = 1'b1;
    applyStimulus(1'b1, 1'b1, 5);

    @(negedge pixclk);
    reset  = 1'b0;
    fs_cnt = 0;
    ls_cnt = 0;
    repeat (2 * S_HT * S_VT) @(negedge pixclk);
    checkOutput("fs_per_2frames", 32'(fs_cnt), 32'd2);
    checkOutput("ls_per_2frames", 32'(ls_cnt), 32'(2 * S_VA));

    applyStimulus(1'b0, 1'b1, 5 * S_HT);
    applyStimulus(1'b0, 1'b0, S_HT * S_VT + 50);
    applyStimulus(1'b0, 1'b1, 300);
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b0, 1'b1, 700);

    found = 1'b0;
    for (int i = 0; i < 2 * S_HT * S_VT && !found; i++) begin
      @(negedge pixclk);
      found = (sh == 10 && sv == 8 && scnt);
    end
    checkOutput("align_reset_point", 32'(found), 32'd1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 700);

    for (int i = 0; i < 600; i++) begin
      @(negedge pixclk);
      run = ($urandom_range(0, 15) != 0);
    end
    applyStimulus(1'b0, 1'b0, S_HT * S_VT + 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
